axi_mem_tester: RTL and testbench
=================================

AXI_MEM_TESTER -- requirements
Module: axi_mem_tester

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, AXI data width (multiple of 32); ADDR_WIDTH, default 16, byte address width; STRB_WIDTH, default DATA_WIDTH/8, wstrb width; ID_WIDTH, default 8, AXI ID width; BURST_LEN, default 16, beats per burst (1-256); NUM_BURSTS, default 4, bursts per pass (1-65535); BASE_ADDR, default 0, first byte address.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin test pulse
- seed  in  32  pattern seed, sampled at start
- busy  out  1  test running
- done  out  1  test complete, held until next accepted start
- pass  out  1  valid when done; 1 = zero errors
- error_count  out  16  mismatches plus bad responses, saturating
- first_err_addr  out  ADDR_WIDTH  byte address of first error
- m_axi_aw*/w*/b*/ar*/r*  AXI4 master channels matching the team AXI RAM slave port set (id, addr, len, size, burst, lock, cache, prot, valid/ready, data, strb, last, resp).

Function
REQ-003 SHALL sequence states IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (next burst WR_ADDR | RD_ADDR) -> RD_DATA -> (next burst RD_ADDR | IDLE with done=1).
REQ-004 SHALL, in IDLE, accept start only when busy=0; on acceptance latch seed, clear done/pass/error_count/first_err_addr, and assert busy the following cycle.
REQ-005 SHALL ignore start while busy=1.
REQ-006 Burst n (0..NUM_BURSTS-1) address SHALL be BASE_ADDR + n*BURST_LEN*STRB_WIDTH, truncated to ADDR_WIDTH.
REQ-007 Beat pattern SHALL be the 32-bit value (beat byte address zero-extended to 32 bits) XOR seed, replicated across DATA_WIDTH.
REQ-008 AW/AR SHALL drive len=BURST_LEN-1, size=log2(STRB_WIDTH), burst=INCR, id=0, lock=0, cache=4'b0011, prot=3'b000; valid held with stable payload until ready.
REQ-009 wvalid SHALL assert only after the AW handshake; wstrb all ones; wlast=1 exactly on beat BURST_LEN-1; wdata stable until wready.
REQ-010 bready SHALL be 1 only in WR_RESP; rready SHALL be 1 only in RD_DATA.
REQ-011 Each read beat SHALL be compared against REQ-007; each mismatched beat, each bresp!=0, each rresp!=0 beat, and each rlast value differing from (beat==BURST_LEN-1) SHALL add 1 to error_count, saturating at 16'hFFFF; one beat with several faults counts once.
REQ-012 RD_DATA SHALL leave on the handshake of beat BURST_LEN-1 regardless of rlast.
REQ-013 On final read beat SHALL in the next cycle set busy=0, done=1, pass=(error_count==0 including that beat).
REQ-014 BURST_LEN=1 SHALL produce single-beat bursts with wlast=1 on every beat.

Reset
REQ-015 rst SHALL return to IDLE next cycle from any state, mid-burst included, with all valid/ready outputs 0, busy=0, done=0, pass=0, error_count=0, first_err_addr=0.
REQ-016 Reset values SHALL apply on the first cycle after rst high; no outstanding transaction is completed.

Configuration
REQ-017 With macro AXI_MEM_TESTER_ERRLOG_EN defined, first_err_addr SHALL capture the byte address of the first erroring beat (write-response errors log the burst start address) and hold until next start.
REQ-018 Without AXI_MEM_TESTER_ERRLOG_EN, first_err_addr SHALL be tied to 0 and no capture logic built; counting unchanged.

Structure
REQ-019 Shared package SHALL hold state enumeration, AXI burst/resp constants (INCR, OKAY, SLVERR) and cache/prot defaults.
REQ-020 Pattern generation SHALL be one combinational sub-module axi_mem_tester_pattern (address, seed -> data), used by write and compare paths.
REQ-021 Parameter checks SHALL error if DATA_WIDTH%32!=0, BURST_LEN outside 1-256, or BURST_LEN*STRB_WIDTH>4096.

Verification
REQ-022 DW=32, BURST_LEN=4, NUM_BURSTS=2, BASE_ADDR=0, seed=0, driving an AXI RAM -> 8 writes data 0x0,0x4..0x1C, done=1, pass=1, error_count=0.
REQ-023 Same, bench corrupts RAM word at 0x8 after writes -> error_count=1, pass=0, first_err_addr=0x8 (macro on) / 0x0 (macro off).
REQ-024 Slave returns bresp=2'b10 on burst 1 -> error_count=1, first_err_addr=0x10, pass=0.
REQ-025 Random awready/wready/arready/rvalid stalls, seed=0xA5A5A5A5 -> payload stable while stalled, wlast on beat 3, pass=1.
REQ-026 rst asserted mid WR_DATA, then start -> outputs reset next cycle, full clean rerun pass=1; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/axi_mem_tester_pkg.sv
// Shared definitions for the AXI memory tester: FSM states, AXI encodings,
// default attributes and the saturating error-counter helper.
package axi_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR   = 2'b10;
  localparam logic [3:0]  AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0]  AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [15:0] ERR_COUNT_MAX     = 16'hFFFF;

  // Increment an error counter, sticking at the maximum value
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == ERR_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi_mem_tester_pattern.sv
// Test pattern generator: 32-bit (byte address XOR seed), replicated across
// the full data width. One instance feeds both the write data and the
// read compare so the two can never disagree.
module axi_mem_tester_pattern
  import axi_mem_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           seed,
  output logic [DATA_WIDTH-1:0] data
);

  logic [31:0] word;

  // Zero-extend the address, mix in the seed and replicate
  always_comb begin
    word = 32'(addr) ^ seed;
    data = {(DATA_WIDTH / 32){word}};
  end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes NUM_BURSTS incrementing bursts of a seeded
// pattern, reads them back, and counts data/response/rlast errors.
// Optional macro AXI_MEM_TESTER_ERRLOG_EN builds first-error address capture;
// without it first_err_addr is tied to zero.
module axi_mem_tester
  import axi_mem_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int                  BURST_BYTES = BURST_LEN * STRB_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [8:0]            LAST_BEAT  = 9'(BURST_LEN - 1);
  localparam logic [15:0]           LAST_BURST = 16'(NUM_BURSTS - 1);

  if (DATA_WIDTH % 32 != 0) begin : g_bad_data_width
    $error("axi_mem_tester: DATA_WIDTH must be a multiple of 32");
  end
  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
    $error("axi_mem_tester: BURST_LEN must be in 1..256");
  end
  if (BURST_BYTES > 4096) begin : g_bad_burst_bytes
    $error("axi_mem_tester: a burst must not exceed 4096 bytes");
  end

  state_t                state, state_next;
  logic [15:0]           burst_idx;
  logic [8:0]            beat_idx;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [31:0]           seed_q;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  last_beat;
  logic                  last_burst;
  logic                  b_err;
  logic                  rd_err;
  logic                  unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  axi_mem_tester_pattern #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pattern (
    .addr(beat_addr),
    .seed(seed_q),
    .data(pattern)
  );

  assign last_beat  = (beat_idx == LAST_BEAT);
  assign last_burst = (burst_idx == LAST_BURST);
  assign b_err      = (m_axi_bresp != AXI_RESP_OKAY);
  assign rd_err     = (m_axi_rdata != pattern) || (m_axi_rresp != AXI_RESP_OKAY) ||
                      (m_axi_rlast != last_beat);

  assign busy          = (state != ST_IDLE);
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = burst_addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = AXI_PROT_DEFAULT;
  assign m_axi_wdata   = pattern;
  assign m_axi_wstrb   = '1;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = burst_addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = AXI_PROT_DEFAULT;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and channel handshake outputs; each channel is active in one state only
  always_comb begin
    state_next    = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_next = ST_WR_ADDR;
      ST_WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = last_beat;
        if (m_axi_wready && last_beat) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = last_burst ? ST_RD_ADDR : ST_WR_ADDR;
      end
      ST_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat) state_next = last_burst ? ST_IDLE : ST_RD_ADDR;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Burst/beat address tracking, error counting and the done/pass result
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_idx   <= '0;
      beat_idx    <= '0;
      burst_addr  <= '0;
      beat_addr   <= '0;
      seed_q      <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          seed_q      <= seed;
          done        <= 1'b0;
          pass        <= 1'b0;
          error_count <= '0;
          burst_idx   <= '0;
          burst_addr  <= BASE;
        end
        ST_WR_ADDR, ST_RD_ADDR: if (m_axi_awvalid && m_axi_awready ||
                                    m_axi_arvalid && m_axi_arready) begin
          beat_idx  <= '0;
          beat_addr <= burst_addr;
        end
        ST_WR_DATA: if (m_axi_wready) begin
          beat_idx  <= beat_idx + 9'd1;
          beat_addr <= beat_addr + BEAT_STEP;
        end
        ST_WR_RESP: if (m_axi_bvalid) begin
          if (b_err) error_count <= sat_inc(error_count);
          if (last_burst) begin
            burst_idx  <= '0;
            burst_addr <= BASE;
          end else begin
            burst_idx  <= burst_idx + 16'd1;
            burst_addr <= burst_addr + BURST_STEP;
          end
        end
        ST_RD_DATA: if (m_axi_rvalid) begin
          if (rd_err) error_count <= sat_inc(error_count);
          beat_idx  <= beat_idx + 9'd1;
          beat_addr <= beat_addr + BEAT_STEP;
          if (last_beat) begin
            if (last_burst) begin
              done <= 1'b1;
              pass <= (error_count == 16'd0) && !rd_err;
            end else begin
              burst_idx  <= burst_idx + 16'd1;
              burst_addr <= burst_addr + BURST_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_MEM_TESTER_ERRLOG_EN
  logic                  err_logged;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  log_event;
  logic [ADDR_WIDTH-1:0] log_addr;

  assign log_event = (m_axi_bvalid && m_axi_bready && b_err) ||
                     (m_axi_rvalid && m_axi_rready && rd_err);
  assign log_addr  = m_axi_bready ? burst_addr : beat_addr;

  // Capture the address of the first erroring beat (burst start for write responses)
  always_ff @(posedge clk) begin
    if (rst) begin
      err_logged <= 1'b0;
      err_addr_q <= '0;
    end else if (state == ST_IDLE && start) begin
      err_logged <= 1'b0;
      err_addr_q <= '0;
    end else if (log_event && !err_logged) begin
      err_logged <= 1'b1;
      err_addr_q <= log_addr;
    end
  end

  assign first_err_addr = err_addr_q;
`else
  assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_axi_mem_tester.sv
// Directed testbench for axi_mem_tester with a small reactive AXI RAM model.
// Expected first_err_addr values follow AXI_MEM_TESTER_ERRLOG_EN.
module tb_axi_mem_tester;
  import axi_mem_tester_pkg::*;

`ifdef AXI_MEM_TESTER_ERRLOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] error_count, first_err_addr;
  logic [7:0]  m_axi_awid, m_axi_arid;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [31:0] m_axi_wdata, m_axi_rdata;

  int checks = 0;
  int fails  = 0;

  logic        stall_en = 1'b0, corrupt_en = 1'b0, rlast_flip = 1'b0, bresp_inject = 1'b0;
  logic [15:0] corrupt_addr = 16'h0;

  logic [31:0] mem [0:63];
  logic [31:0] wr_log [0:15];
  logic [15:0] wr_ptr, rd_ptr;
  logic [1:0]  wr_beat;
  int          wr_n, wlast_bad, b_cnt, rd_left;
  logic        w_open;

  int          stable_bad, order_bad, attr_bad, stall_seen;
  logic        p_aw_stall, p_w_stall, p_ar_stall, p_wlast;
  logic [15:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  axi_mem_tester #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8),
    .BURST_LEN(4), .NUM_BURSTS(2), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(8'd0), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(8'd0), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Random ready/valid gating when stalls are enabled
  function automatic logic go();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Read word as returned by the slave, with optional injected corruption
  function automatic logic [31:0] rd_word(input logic [15:0] a);
    return mem[a[7:2]] ^ ((corrupt_en && a == corrupt_addr) ? 32'hFFFF_FFFF : 32'h0);
  endfunction

  // rlast as returned by the slave, with optional injected inversion
  function automatic logic rd_last(input logic [15:0] a, input int left);
    return (left == 1) ^ (rlast_flip && a == corrupt_addr);
  endfunction

  // AXI RAM slave model: one outstanding write and read burst, 4 beats each
  always @(posedge clk) begin
    if (rst) begin
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_arready <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= AXI_RESP_OKAY;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= AXI_RESP_OKAY; m_axi_rlast <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0; wr_beat <= '0; wr_n <= 0; wlast_bad <= 0;
      b_cnt <= 0; rd_left <= 0; w_open <= 1'b0;
    end else begin
      m_axi_awready <= go();
      m_axi_wready  <= go();
      m_axi_arready <= go();
      if (m_axi_awvalid && m_axi_awready) begin
        wr_ptr <= m_axi_awaddr;
        w_open <= 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        mem[wr_ptr[7:2]] <= m_axi_wdata;
        wr_ptr <= wr_ptr + 16'd4;
        if (wr_n < 16) wr_log[wr_n] <= m_axi_wdata;
        wr_n <= wr_n + 1;
        if (m_axi_wlast !== (wr_beat == 2'd3)) wlast_bad <= wlast_bad + 1;
        wr_beat <= wr_beat + 2'd1;
        if (wr_beat == 2'd3) begin
          w_open       <= 1'b0;
          m_axi_bvalid <= 1'b1;
          m_axi_bresp  <= (bresp_inject && b_cnt == 1) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
        b_cnt        <= b_cnt + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        rd_ptr  <= m_axi_araddr;
        rd_left <= 4;
      end else if (m_axi_rvalid && m_axi_rready) begin
        rd_ptr  <= rd_ptr + 16'd4;
        rd_left <= rd_left - 1;
      end
      if (!(m_axi_rvalid && !m_axi_rready)) begin
        if (m_axi_rvalid) begin
          if (rd_left > 1 && go()) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= rd_word(rd_ptr + 16'd4);
            m_axi_rlast  <= rd_last(rd_ptr + 16'd4, rd_left - 1);
          end else begin
            m_axi_rvalid <= 1'b0;
          end
        end else if (rd_left > 0 && go()) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rdata  <= rd_word(rd_ptr);
          m_axi_rlast  <= rd_last(rd_ptr, rd_left);
        end
      end
    end
  end

  // Protocol monitor: stalled payload stability, W-after-AW ordering, fixed attributes
  always @(negedge clk) begin
    if (rst) begin
      stable_bad <= 0; order_bad <= 0; attr_bad <= 0; stall_seen <= 0;
      p_aw_stall <= 1'b0; p_w_stall <= 1'b0; p_ar_stall <= 1'b0;
    end else begin
      if ((p_aw_stall && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) ||
          (p_w_stall && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wlast !== p_wlast)) ||
          (p_ar_stall && (!m_axi_arvalid || m_axi_araddr !== p_araddr)))
        stable_bad <= stable_bad + 1;
      if (m_axi_wvalid && !w_open) order_bad <= order_bad + 1;
      if ((m_axi_awvalid && {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                             m_axi_awcache, m_axi_awprot} !== {8'd0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) ||
          (m_axi_arvalid && {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                             m_axi_arcache, m_axi_arprot} !== {8'd0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) ||
          (m_axi_wvalid && m_axi_wstrb !== 4'hF))
        attr_bad <= attr_bad + 1;
      if ((m_axi_awvalid && !m_axi_awready) || (m_axi_wvalid && !m_axi_wready) ||
          (m_axi_arvalid && !m_axi_arready) || (m_axi_rready && !m_axi_rvalid))
        stall_seen <= stall_seen + 1;
      p_aw_stall <= m_axi_awvalid && !m_axi_awready;
      p_w_stall  <= m_axi_wvalid && !m_axi_wready;
      p_ar_stall <= m_axi_arvalid && !m_axi_arready;
      p_awaddr   <= m_axi_awaddr;
      p_araddr   <= m_axi_araddr;
      p_wdata    <= m_axi_wdata;
      p_wlast    <= m_axi_wlast;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge following the accepting clock edge
  task automatic pulse_start(input logic [31:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (error_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_errcnt: got %h expected 0", error_count); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_handshakes: got %b expected 00000",
                        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
  endtask

  task automatic test_clean();
    bit to;
    do_reset();
    pulse_start(32'h0);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL clean_busy_after_start: got %b expected 1", busy); end
    wait_done(to);
    checks++; if (to) begin fails++; $display("[TB] FAIL clean_timeout: done=%b expected 1", done); end
    checks++; if (pass !== 1'b1) begin fails++; $display("[TB] FAIL clean_pass: got %b expected 1", pass); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL clean_busy_at_done: got %b expected 0", busy); end
    checks++; if (error_count !== 16'h0) begin fails++; $display("[TB] FAIL clean_errcnt: got %h expected 0", error_count); end
    checks++; if (first_err_addr !== 16'h0) begin fails++; $display("[TB] FAIL clean_first_err: got %h expected 0", first_err_addr); end
    checks++; if (wr_n !== 8) begin fails++; $display("[TB] FAIL clean_write_beats: got %0d expected 8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_log[i] !== 32'(i * 4)) begin
        fails++; $display("[TB] FAIL clean_wdata[%0d]: got %h expected %h", i, wr_log[i], 32'(i * 4));
      end
    end
    checks++; if (wlast_bad !== 0) begin fails++; $display("[TB] FAIL clean_wlast: got %0d bad beats expected 0", wlast_bad); end
    checks++; if (attr_bad !== 0) begin fails++; $display("[TB] FAIL clean_attrs: got %0d bad cycles expected 0", attr_bad); end
    checks++; if (order_bad !== 0) begin fails++; $display("[TB] FAIL clean_w_order: got %0d bad cycles expected 0", order_bad); end
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL clean_done_held: got %b expected 1", done); end
  endtask

  task automatic test_corrupt();
    bit to;
    do_reset();
    corrupt_en = 1'b1; corrupt_addr = 16'h0008;
    pulse_start(32'h0);
    wait_done(to);
    corrupt_en = 1'b0;
    checks++; if (to) begin fails++; $display("[TB] FAIL corrupt_timeout: done=%b expected 1", done); end
    checks++; if (error_count !== 16'd1) begin fails++; $display("[TB] FAIL corrupt_errcnt: got %h expected 1", error_count); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL corrupt_pass: got %b expected 0", pass); end
    checks++; if (first_err_addr !== (LOG_ON ? 16'h0008 : 16'h0)) begin
      fails++; $display("[TB] FAIL corrupt_first_err: got %h expected %h", first_err_addr, LOG_ON ? 16'h0008 : 16'h0);
    end
    pulse_start(32'h0);
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL restart_clears_done: got %b expected 0", done); end
    checks++; if (error_count !== 16'h0) begin fails++; $display("[TB] FAIL restart_clears_errcnt: got %h expected 0", error_count); end
    checks++; if (first_err_addr !== 16'h0) begin fails++; $display("[TB] FAIL restart_clears_first_err: got %h expected 0", first_err_addr); end
    wait_done(to);
    checks++; if (to || pass !== 1'b1) begin fails++; $display("[TB] FAIL restart_pass: got %b expected 1 (timeout=%0d)", pass, to); end
  endtask

  task automatic test_bresp();
    bit to;
    do_reset();
    bresp_inject = 1'b1;
    pulse_start(32'h0);
    wait_done(to);
    bresp_inject = 1'b0;
    checks++; if (to) begin fails++; $display("[TB] FAIL bresp_timeout: done=%b expected 1", done); end
    checks++; if (error_count !== 16'd1) begin fails++; $display("[TB] FAIL bresp_errcnt: got %h expected 1", error_count); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL bresp_pass: got %b expected 0", pass); end
    checks++; if (first_err_addr !== (LOG_ON ? 16'h0010 : 16'h0)) begin
      fails++; $display("[TB] FAIL bresp_first_err: got %h expected %h", first_err_addr, LOG_ON ? 16'h0010 : 16'h0);
    end
  endtask

  // Bad data and wrong rlast on the very last beat: counted once, run still ends
  task automatic test_multi_fault();
    bit to;
    do_reset();
    corrupt_en = 1'b1; rlast_flip = 1'b1; corrupt_addr = 16'h001C;
    pulse_start(32'h0);
    wait_done(to);
    corrupt_en = 1'b0; rlast_flip = 1'b0;
    checks++; if (to) begin fails++; $display("[TB] FAIL multi_timeout: done=%b expected 1", done); end
    checks++; if (error_count !== 16'd1) begin fails++; $display("[TB] FAIL multi_errcnt: got %h expected 1", error_count); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL multi_pass: got %b expected 0", pass); end
    checks++; if (first_err_addr !== (LOG_ON ? 16'h001C : 16'h0)) begin
      fails++; $display("[TB] FAIL multi_first_err: got %h expected %h", first_err_addr, LOG_ON ? 16'h001C : 16'h0);
    end
  endtask

  task automatic test_stalls();
    bit to;
    do_reset();
    stall_en = 1'b1;
    pulse_start(32'hA5A5_A5A5);
    wait_done(to);
    stall_en = 1'b0;
    checks++; if (to) begin fails++; $display("[TB] FAIL stall_timeout: done=%b expected 1", done); end
    checks++; if (pass !== 1'b1) begin fails++; $display("[TB] FAIL stall_pass: got %b expected 1", pass); end
    checks++; if (stable_bad !== 0) begin fails++; $display("[TB] FAIL stall_stability: got %0d bad cycles expected 0", stable_bad); end
    checks++; if (wlast_bad !== 0) begin fails++; $display("[TB] FAIL stall_wlast: got %0d bad beats expected 0", wlast_bad); end
    checks++; if (order_bad !== 0) begin fails++; $display("[TB] FAIL stall_w_order: got %0d bad cycles expected 0", order_bad); end
    checks++; if (wr_log[3] !== 32'hA5A5_A5A9) begin fails++; $display("[TB] FAIL stall_wdata3: got %h expected a5a5a5a9", wr_log[3]); end
    checks++; if (wr_log[7] !== 32'hA5A5_A5B9) begin fails++; $display("[TB] FAIL stall_wdata7: got %h expected a5a5a5b9", wr_log[7]); end
    checks++; if (stall_seen == 0) begin fails++; $display("[TB] FAIL stall_occurred: got %0d stall cycles expected >0", stall_seen); end
  endtask

  task automatic test_midburst_reset();
    bit to;
    bit seen;
    do_reset();
    pulse_start(32'h0);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (m_axi_wvalid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL midrst_reach_wdata: got wvalid=%b expected 1", m_axi_wvalid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      fails++; $display("[TB] FAIL midrst_handshakes: got %b expected 00000",
                        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    checks++; if ({done, pass} !== 2'b00) begin fails++; $display("[TB] FAIL midrst_done_pass: got %b expected 00", {done, pass}); end
    rst = 1'b0;
    pulse_start(32'h0F0F_0000);
    wait_done(to);
    checks++; if (to || pass !== 1'b1) begin fails++; $display("[TB] FAIL midrst_rerun_pass: got %b expected 1 (timeout=%0d)", pass, to); end
    checks++; if (wr_n !== 8) begin fails++; $display("[TB] FAIL midrst_rerun_beats: got %0d expected 8", wr_n); end
  endtask

  task automatic test_busy_start();
    bit to;
    do_reset();
    pulse_start(32'h1111_0000);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busystart_busy: got %b expected 1", busy); end
    pulse_start(32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    pulse_start(32'hDEAD_BEEF);
    wait_done(to);
    checks++; if (to || pass !== 1'b1) begin fails++; $display("[TB] FAIL busystart_pass: got %b expected 1 (timeout=%0d)", pass, to); end
    checks++; if (wr_n !== 8) begin fails++; $display("[TB] FAIL busystart_beats: got %0d expected 8", wr_n); end
    checks++; if (wr_log[7] !== 32'h1111_001C) begin fails++; $display("[TB] FAIL busystart_wdata7: got %h expected 1111001c", wr_log[7]); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0;
    test_reset();
    test_clean();
    test_corrupt();
    test_bresp();
    test_multi_fault();
    test_stalls();
    test_midburst_reset();
    test_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
